// File: rtl/mux4x1_2_pkg.sv
// Shared constants for the mux_4x1_2 selector: select encodings and counter width.
package mux4x1_2_pkg;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

    localparam int SEL_CNT_W = 8;

endpackage

// File: rtl/mux4_comb.sv
// Parameterised combinational 4:1 selector. An unknown select drives an unknown
// output in simulation rather than silently falling back to i0.
module mux4_comb
    import mux4x1_2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // select the addressed word; all bits of the word use the same select
    always_comb begin
        y = 'x;
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4x1_2.sv
// Four-to-one data selector with a registered copy of the output.
// Optional select-change counter enabled by defining MUX4X1_2_SEL_CNT_EN.
module mux_4x1_2
    import mux4x1_2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i0,
    input  logic [WIDTH-1:0]     i1,
    input  logic [WIDTH-1:0]     i2,
    input  logic [WIDTH-1:0]     i3,
    input  logic                 s0,
    input  logic                 s1,
    output logic [WIDTH-1:0]     y,
    output logic [WIDTH-1:0]     y_q
`ifdef MUX4X1_2_SEL_CNT_EN
    ,
    output logic [SEL_CNT_W-1:0] sel_chg_cnt
`endif
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] y_d;

    assign sel = {s1, s0};

    mux4_comb #(.WIDTH(WIDTH)) u_mux4_comb (
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .sel (sel),
        .y   (y)
    );

    // next value of the registered output: cleared by reset, else follows y
    always_comb begin
        y_d = y;
        if (rst) begin
            y_d = '0;
        end
    end

    // registered copy of y
    always_ff @(posedge clk) begin
        y_q <= y_d;
    end

`ifdef MUX4X1_2_SEL_CNT_EN
    logic [1:0]           sel_prev_d;
    logic [1:0]           sel_prev_q;
    logic [SEL_CNT_W-1:0] sel_chg_cnt_d;
    logic [SEL_CNT_W-1:0] sel_chg_cnt_q;

    // count edges where the select differs from the previous edge, saturating
    always_comb begin
        sel_prev_d    = sel;
        sel_chg_cnt_d = sel_chg_cnt_q;
        if (rst) begin
            sel_prev_d    = SEL_I0;
            sel_chg_cnt_d = '0;
        end else if ((sel != sel_prev_q) && (sel_chg_cnt_q != {SEL_CNT_W{1'b1}})) begin
            sel_chg_cnt_d = sel_chg_cnt_q + 1'b1;
        end
    end

    // previous-select and counter registers
    always_ff @(posedge clk) begin
        sel_prev_q    <= sel_prev_d;
        sel_chg_cnt_q <= sel_chg_cnt_d;
    end

    assign sel_chg_cnt = sel_chg_cnt_q;
`endif

endmodule

// File: tb/tb_mux_4x1_2.sv
// Scoreboard bench for mux_4x1_2: a WIDTH=1 and a WIDTH=8 instance share the selects.
module tb_mux_4x1_2;

    typedef enum int {K_Y1, K_Y8, K_YQ1, K_YQ8, K_CNT} kind_t;

    typedef struct {
        kind_t      kind;
        logic [7:0] exp;
        string      name;
    } item_t;

    item_t      sb_q[$];
    event       chk_ev;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       s0 = 1'b0;
    logic       s1 = 1'b0;
    logic [0:0] a0 = 1'b1, a1 = 1'b0, a2 = 1'b1, a3 = 1'b0;
    logic [7:0] b0 = 8'hA5, b1 = 8'h3C, b2 = 8'hFF, b3 = 8'h00;
    logic [0:0] y1, yq1;
    logic [7:0] y8, yq8;
    logic [7:0] cnt1, cnt8;

    always #5 if (clk_en) clk = ~clk;

    mux_4x1_2 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .i0(a0), .i1(a1), .i2(a2), .i3(a3),
        .s0(s0), .s1(s1), .y(y1), .y_q(yq1)
`ifdef MUX4X1_2_SEL_CNT_EN
        , .sel_chg_cnt(cnt1)
`endif
    );

    mux_4x1_2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .i0(b0), .i1(b1), .i2(b2), .i3(b3),
        .s0(s0), .s1(s1), .y(y8), .y_q(yq8)
`ifdef MUX4X1_2_SEL_CNT_EN
        , .sel_chg_cnt(cnt8)
`endif
    );

`ifndef MUX4X1_2_SEL_CNT_EN
    assign cnt1 = '0;
    assign cnt8 = '0;
`endif

    // monitor: pops every queued expectation when the stimulus says outputs are settled
    initial begin
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                item_t it;
                logic [7:0] act;
                it = sb_q.pop_front();
                case (it.kind)
                    K_Y1:    act = {7'd0, y1};
                    K_Y8:    act = y8;
                    K_YQ1:   act = {7'd0, yq1};
                    K_YQ8:   act = yq8;
                    default: act = cnt8;
                endcase
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_val(input kind_t k, input logic [7:0] e, input string nm);
        item_t it;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        sb_q.push_back(it);
    endtask

    task automatic settle();
        #1 -> chk_ev;
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {s1, s0} = s;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w8 [4];
        logic [0:0] w1 [4];
        w8[0] = 8'hA5; w8[1] = 8'h3C; w8[2] = 8'hFF; w8[3] = 8'h00;
        w1[0] = 1'b1;  w1[1] = 1'b0;  w1[2] = 1'b1;  w1[3] = 1'b0;

        // combinational path with no clock running
        for (int s = 0; s < 4; s++) begin
            set_sel(2'(s));
            #2;
            expect_val(K_Y1, {7'd0, w1[s]}, $sformatf("y1_sel%0d", s));
            expect_val(K_Y8, w8[s], $sformatf("y8_sel%0d", s));
            settle();
        end

        // reset for two edges with y=1
        clk_en = 1'b1;
        set_sel(2'b00);
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            expect_val(K_YQ1, 8'h00, $sformatf("yq1_rst_edge%0d", e));
            expect_val(K_YQ8, 8'h00, $sformatf("yq8_rst_edge%0d", e));
            settle();
        end
        rst = 1'b0;
        tick();
        expect_val(K_YQ1, 8'h01, "yq1_after_rst");
        expect_val(K_YQ8, 8'hA5, "yq8_after_rst");
        settle();

        // registered path follows each select with one edge of latency
        for (int s = 1; s < 4; s++) begin
            set_sel(2'(s));
            #1;
            expect_val(K_YQ1, {7'd0, w1[s-1]}, $sformatf("yq1_hold_sel%0d", s));
            settle();
            tick();
            expect_val(K_YQ1, {7'd0, w1[s]}, $sformatf("yq1_sel%0d", s));
            expect_val(K_YQ8, w8[s], $sformatf("yq8_sel%0d", s));
            settle();
        end

        // mid-stream reset with y_q=1; y keeps tracking
        set_sel(2'b10);
        tick();
        expect_val(K_YQ1, 8'h01, "yq1_pre_midrst");
        settle();
        rst = 1'b1;
        tick();
        expect_val(K_YQ1, 8'h00, "yq1_midrst");
        expect_val(K_YQ8, 8'h00, "yq8_midrst");
        expect_val(K_Y8, 8'hFF, "y8_during_rst");
        settle();
        set_sel(2'b01);
        #1;
        expect_val(K_Y8, 8'h3C, "y8_track_in_rst");
        expect_val(K_Y1, 8'h00, "y1_track_in_rst");
        settle();
        rst = 1'b0;
        tick();
        expect_val(K_YQ8, 8'h3C, "yq8_post_midrst");
        settle();

`ifdef MUX4X1_2_SEL_CNT_EN
        // select-change counter: a change on every edge, then hold
        rst = 1'b1;
        set_sel(2'b00);
        tick();
        tick();
        expect_val(K_CNT, 8'd0, "cnt_reset");
        settle();
        rst = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            set_sel(2'(k));
            tick();
            if (k == 1 || k == 10 || k == 254 || k == 255 || k == 256 || k == 300) begin
                expect_val(K_CNT, (k > 255) ? 8'd255 : 8'(k), $sformatf("cnt_after_%0d", k));
                settle();
            end
        end
        for (int k = 0; k < 5; k++) tick();
        expect_val(K_CNT, 8'd255, "cnt_hold");
        settle();
        rst = 1'b1;
        tick();
        expect_val(K_CNT, 8'd0, "cnt_clear");
        settle();
        rst = 1'b0;
        set_sel(2'b00);
        for (int k = 0; k < 3; k++) tick();
        expect_val(K_CNT, 8'd0, "cnt_hold_zero");
        set_sel(2'b11);
        tick();
        expect_val(K_CNT, 8'd1, "cnt_one_change");
        settle();
`endif

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
